ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Sequencer sitting directly upstream of the team's 8x8 chip-select RAM (ports: clk, in, adress, cs, reset, re, we, out).
- Turns a byte-stream push/pop handshake into RAM control cycles: write pointer, read pointer, occupancy count, full/empty flags.
- Also provides a one-shot clear that pulses the RAM's active-low reset.
- The RAM is used as circular FIFO storage; this block owns every RAM control pin.

Parameters:
- DATA_W, 8, byte width of push/pop data and RAM data.
- ADDR_W, 3, RAM address width.
- DEPTH, 8, FIFO capacity in entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  request to write push_data; accepted only when push_ready=1.
- push_data  in  DATA_W  byte to store.
- push_ready  out  1  push will be accepted on this edge.
- pop  in  1  request to read oldest entry; accepted only when pop_ready=1.
- pop_ready  out  1  pop will be accepted on this edge.
- pop_data  out  DATA_W  registered read result.
- pop_valid  out  1  one-cycle pulse; pop_data is new.
- clear  in  1  flush FIFO and zero RAM contents.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- mem_adress  out  ADDR_W  to RAM adress.
- mem_in  out  DATA_W  to RAM in.
- mem_cs  out  1  to RAM cs.
- mem_we  out  1  to RAM we.
- mem_re  out  1  to RAM re.
- mem_reset  out  1  to RAM reset (active-low).
- mem_out  in  DATA_W  from RAM out.

Behaviour:
- RAM contract: write occurs at the rising edge while cs=1 and we=1. Read data is valid combinationally on out while cs=1 and re=1. RAM reset=0 zeroes all words.
- Reset (reset=0, async):
  - state=IDLE; wr_ptr=rd_ptr=count=0.
  - pop_data=0, pop_valid=0, push_ready=0, pop_ready=0.
  - mem_cs=mem_we=mem_re=0, mem_adress=0, mem_in=0.
  - mem_reset=1 (the RAM is not cleared by this block's reset).
- All mem_* outputs are registered; they are driven from the state register only.
- FSM states: IDLE, WR, RD, CLR.
  - IDLE -> CLR if clear=1 (highest priority).
  - Else IDLE -> RD if pop=1 and !empty (pop beats push).
  - Else IDLE -> WR if push=1 and !full.
  - Else stay in IDLE.
  - WR, RD, CLR each last exactly one cycle, then return to IDLE.
- push_ready = (state==IDLE) && !full && !clear && !(pop && !empty).
- pop_ready = (state==IDLE) && !empty && !clear.
- Sustained throughput is one operation per two cycles.
- WR cycle:
  - mem_cs=1, mem_we=1, mem_re=0, mem_adress=wr_ptr, mem_in=byte latched at accept.
  - At the end of the cycle: wr_ptr+1 (wraps 7->0) and count+1.
- RD cycle:
  - mem_cs=1, mem_re=1, mem_we=0, mem_adress=rd_ptr.
  - At the end of the cycle: pop_data<=mem_out, rd_ptr+1 (wraps), count-1, pop_valid<=1 for the next cycle only.
  - Latency: pop accepted at edge N; pop_valid=1 during cycle N+1..N+2 boundary (after edge N+1).
- CLR cycle:
  - mem_reset=0, mem_cs=0.
  - At the end of the cycle: wr_ptr=rd_ptr=count=0; pop_data is unchanged.
- Boundaries:
  - push while full: ignored, no pointer change.
  - pop while empty: ignored, pop_valid stays 0.
  - Wrap-around: pointers wrap modulo DEPTH; full and empty are distinguished by count, not by pointer equality.
  - A clear arriving while in WR/RD is held off; it is sampled again in the following IDLE cycle only if still asserted.
  - Async reset mid-WR/RD: the operation is abandoned; mem_cs/we/re drop immediately.
- Outside WR/RD/CLR: mem_cs=0, mem_we=0, mem_re=0, mem_reset=1.

Test Plan:
- Reset, then push 0x0A..0x11 (8 bytes, one per accept) -> RAM addresses 0..7 hold 0x0A..0x11; full=1, count=8, push_ready=0; a 9th push of 0x55 leaves RAM unchanged.
- Pop 8 times -> pop_data sequence 0x0A..0x11, each pop_valid is a single-cycle pulse one edge after the RD cycle; ends with empty=1, count=0; a further pop gives no pop_valid.
- Wrap: push 5, pop 5, push 6 bytes 0x20..0x25 -> writes land at addresses 5,6,7,0,1,2; pops return 0x20..0x25 in order.
- Simultaneous push=1 and pop=1 with count=3 -> RD runs first (push_ready=0 that cycle); push is accepted in the next IDLE cycle; count goes 3->2->3.
- clear with count=4 -> one CLR cycle with mem_reset=0; afterwards count=0 and empty=1; a RAM read of every address returns 0x00.
- Assert reset=0 during a WR cycle -> mem_we drops asynchronously; count=0, pointers=0, pop_valid=0 immediately.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer for the 8x8 chip-select RAM: turns push/pop handshakes into
// registered RAM control cycles and owns pointers, occupancy and the RAM clear.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  input  logic              clear,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_reset,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, WR, RD, CLR} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state, next_state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Clear outranks pop, pop outranks push; every operation is a single cycle.
  always_comb begin
    next_state = IDLE;
    if (state == IDLE) begin
      if (clear)              next_state = CLR;
      else if (pop && !empty) next_state = RD;
      else if (push && !full) next_state = WR;
    end
  end

  // Ready flags are forced low while reset is held so nothing looks acceptable.
  always_comb begin
    push_ready = 1'b0;
    pop_ready  = 1'b0;
    if (reset && state == IDLE) begin
      push_ready = !full && !clear && !(pop && !empty);
      pop_ready  = !empty && !clear;
    end
  end

  // RAM controls are registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_reset  <= 1'b1;
      mem_adress <= '0;
      mem_in     <= '0;
    end else begin
      mem_cs    <= (next_state == WR) || (next_state == RD);
      mem_we    <= (next_state == WR);
      mem_re    <= (next_state == RD);
      mem_reset <= (next_state != CLR);
      if (next_state == WR) begin
        mem_adress <= wr_ptr;
        mem_in     <= push_data;
      end else if (next_state == RD) begin
        mem_adress <= rd_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        WR: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          count  <= count + (ADDR_W+1)'(1);
        end
        RD: begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
          count  <= count - (ADDR_W+1)'(1);
        end
        CLR: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read data is captured at the end of the RD cycle while the RAM drives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= (state == RD);
      if (state == RD) pop_data <= mem_out;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural model of the 8x8 RAM.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0, pop = 1'b0, clear = 1'b0;
  logic [7:0] push_data = '0;
  logic       push_ready, pop_ready, pop_valid, full, empty;
  logic [7:0] pop_data;
  logic [3:0] count;
  logic [2:0] mem_adress;
  logic [7:0] mem_in, mem_out;
  logic       mem_cs, mem_we, mem_re, mem_reset;

  logic [7:0] ram [8];
  logic [7:0] fifoModel [$];
  logic [7:0] popQ [$];
  logic [10:0] writeQ [$];
  logic [2:0] expWr = '0;
  int vectors = 0;
  int miscompares = 0;
  logic prevValid = 1'b0;

  ram_fifo_ctrl dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data),
    .push_ready(push_ready), .pop(pop), .pop_ready(pop_ready),
    .pop_data(pop_data), .pop_valid(pop_valid), .clear(clear),
    .count(count), .full(full), .empty(empty), .mem_adress(mem_adress),
    .mem_in(mem_in), .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
    .mem_reset(mem_reset), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // RAM: synchronous write on cs&we, combinational read on cs&re, reset=0 zeroes.
  always @(posedge clk or negedge mem_reset) begin
    if (!mem_reset) begin
      for (int i = 0; i < 8; i++) ram[i] <= 8'h00;
    end else if (mem_cs && mem_we) begin
      ram[mem_adress] <= mem_in;
    end
  end

  always_comb mem_out = (mem_cs && mem_re) ? ram[mem_adress] : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: compares every RAM write and every pop_valid pulse against the queues.
  always @(negedge clk) begin
    if (mem_cs && mem_we) begin
      if (writeQ.size() == 0) checkOutput("unexpected_write", {21'd0, mem_adress, mem_in}, 32'hFFFF);
      else checkOutput("ram_write", {21'd0, mem_adress, mem_in}, {21'd0, writeQ.pop_front()});
    end
    if (pop_valid) begin
      if (prevValid) checkOutput("pop_valid_width", 32'd2, 32'd1);
      if (popQ.size() == 0) checkOutput("unexpected_pop", {24'd0, pop_data}, 32'hFFFF);
      else checkOutput("pop_data", {24'd0, pop_data}, {24'd0, popQ.pop_front()});
    end
    prevValid = pop_valid;
  end

  task automatic applyStimulus(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!push_ready && n < 20) begin @(negedge clk); n++; end
    if (!push_ready) begin
      checkOutput("push_timeout", 32'd0, 32'd1);
      return;
    end
    push = 1'b1;
    push_data = d;
    writeQ.push_back({expWr, d});
    fifoModel.push_back(d);
    expWr++;
    @(posedge clk);
    #1 push = 1'b0;
  endtask

  task automatic doPop();
    int n = 0;
    @(negedge clk);
    while (!pop_ready && n < 20) begin @(negedge clk); n++; end
    if (!pop_ready || fifoModel.size() == 0) begin
      checkOutput("pop_timeout", 32'd0, 32'd1);
      return;
    end
    pop = 1'b1;
    popQ.push_back(fifoModel.pop_front());
    @(posedge clk);
    #1 pop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pop_latency", {31'd0, pop_valid}, 32'd1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 8'hEE;
    #12;
    checkOutput("reset_count", {28'd0, count}, 32'd0);
    checkOutput("reset_push_ready", {31'd0, push_ready}, 32'd0);
    checkOutput("reset_pop_valid", {31'd0, pop_valid}, 32'd0);
    checkOutput("reset_mem_ctl", {28'd0, mem_cs, mem_we, mem_re, mem_reset}, 32'h1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(8'h0A + 8'(i));
    settle();
    checkOutput("full_count", {28'd0, count}, 32'd8);
    checkOutput("full_flag", {31'd0, full}, 32'd1);
    checkOutput("full_push_ready", {31'd0, push_ready}, 32'd0);
    push = 1'b1;
    push_data = 8'h55;
    repeat (4) @(negedge clk);
    push = 1'b0;
    checkOutput("full_count_after_push", {28'd0, count}, 32'd8);
    for (int i = 0; i < 8; i++) checkOutput("ram_contents", {24'd0, ram[i]}, 32'h0A + i);

    for (int i = 0; i < 8; i++) doPop();
    settle();
    checkOutput("empty_count", {28'd0, count}, 32'd0);
    checkOutput("empty_flag", {31'd0, empty}, 32'd1);
    pop = 1'b1;
    #1 checkOutput("empty_pop_ready", {31'd0, pop_ready}, 32'd0);
    repeat (4) @(negedge clk);
    pop = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) doPop();
    for (int i = 0; i < 6; i++) applyStimulus(8'h20 + 8'(i));
    for (int i = 0; i < 6; i++) doPop();
    settle();
    checkOutput("wrap_empty", {31'd0, empty}, 32'd1);

    for (int i = 0; i < 3; i++) applyStimulus(8'h50 + 8'(i));
    settle();
    checkOutput("pre_sim_count", {28'd0, count}, 32'd3);
    push = 1'b1;
    push_data = 8'h53;
    pop = 1'b1;
    #1;
    checkOutput("sim_push_ready", {31'd0, push_ready}, 32'd0);
    checkOutput("sim_pop_ready", {31'd0, pop_ready}, 32'd1);
    popQ.push_back(fifoModel.pop_front());
    @(posedge clk);
    #1 pop = 1'b0;
    @(negedge clk);
    checkOutput("sim_rd_push_ready", {31'd0, push_ready}, 32'd0);
    @(negedge clk);
    checkOutput("sim_mid_count", {28'd0, count}, 32'd2);
    checkOutput("sim_idle_push_ready", {31'd0, push_ready}, 32'd1);
    writeQ.push_back({expWr, 8'h53});
    fifoModel.push_back(8'h53);
    expWr++;
    @(posedge clk);
    #1 push = 1'b0;
    settle();
    checkOutput("sim_end_count", {28'd0, count}, 32'd3);

    applyStimulus(8'h54);
    settle();
    checkOutput("pre_clear_count", {28'd0, count}, 32'd4);
    clear = 1'b1;
    #1;
    checkOutput("clear_push_ready", {31'd0, push_ready}, 32'd0);
    checkOutput("clear_pop_ready", {31'd0, pop_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("clr_mem_reset", {31'd0, mem_reset}, 32'd0);
    checkOutput("clr_mem_cs", {31'd0, mem_cs}, 32'd0);
    clear = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_clear_count", {28'd0, count}, 32'd0);
    checkOutput("post_clear_empty", {31'd0, empty}, 32'd1);
    checkOutput("post_clear_mem_reset", {31'd0, mem_reset}, 32'd1);
    checkOutput("post_clear_pop_data", {24'd0, pop_data}, 32'h50);
    for (int i = 0; i < 8; i++) checkOutput("cleared_ram", {24'd0, ram[i]}, 32'h0);
    fifoModel.delete();
    expWr = '0;

    applyStimulus(8'h77);
    doPop();

    applyStimulus(8'h60);
    applyStimulus(8'h61);
    @(negedge clk);
    while (!push_ready) @(negedge clk);
    push = 1'b1;
    push_data = 8'h99;
    @(posedge clk);
    #1 push = 1'b0;
    checkOutput("wr_mem_we", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    checkOutput("rst_count", {28'd0, count}, 32'd0);
    checkOutput("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
    checkOutput("rst_push_ready", {31'd0, push_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    fifoModel.delete();
    expWr = '0;
    checkOutput("rst_ram_kept", {24'd0, ram[1]}, 32'h60);
    applyStimulus(8'hA5);
    doPop();

    repeat (4) @(negedge clk);
    checkOutput("writeQ_drained", writeQ.size(), 32'd0);
    checkOutput("popQ_drained", popQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
